decode_sequencer: RTL and testbench
===================================

DECODE_SEQUENCER -- requirements
Module: decode_sequencer

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning data and instruction width.
REQ-002 SHALL have parameter ADDR_W, default 16, meaning address width; the high-byte width is ADDR_W-DATA_W.
REQ-003 SHALL have parameter T_W, default 3, meaning t_state counter width.
REQ-004 SHALL have ports:
- clk_2  in  1  single system clock; all state changes on its rising edge.
- rst  in  1  reset; asynchronous and active-low.
- instruction  in  DATA_W  memory read data (opcode or operand).
- mem_ready  in  1  memory access completes this cycle.
- flush  in  1  abandon the current instruction.
- sync  out  1  opcode fetch cycle (T0).
- w_rd  out  1  1 = memory write, 0 = read.
- pc_data  out  1  1 = address from PC, 0 = from address latches.
- increment  out  1  PC increment.
- lower_byte  out  1  address latch high byte forced to zero (zero page).
- addr_lo_load  out  1  load the address low latch.
- addr_hi_load  out  1  load the address high latch.
- x_con, y_con, accumulator_con, status_con, stack_pointer_con  out  1 each  register write enables.
- branch_uncon, branch_con  out  1 each  branch controls.
- alu_op  out  4  ALU opcode.
- branch_op  out  3  branch condition.
- immediate  out  DATA_W  latched operand.
- t_state  out  T_W  current cycle number.
- illegal  out  1  illegal-opcode trap.

Function
REQ-005 SHALL decode opcodes of the form aaa-bbb-01. aaa selects the operation: ORA=ALU 5, AND=3, EOR=4, ADC=1, STA=store, LDA=PASS(11), CMP=SBC(2) with no accumulator write, SBC=2.
REQ-006 SHALL support these bbb addressing modes:
- 010 immediate: 2 cycles.
- 001 zero page: 3 cycles.
- 011 absolute: 4 cycles.
All other opcodes, and STA immediate (0x89), are illegal.
REQ-007 In T0, SHALL assert sync=1, pc_data=1, increment=1 and w_rd=0, and SHALL load the IR from instruction when mem_ready=1.
REQ-008 Immediate mode: in T1, SHALL assert increment, latch immediate=instruction, and drive alu_op with status_con=1; accumulator_con=1 except for CMP.
REQ-009 Zero page mode:
- T1: addr_lo_load=1, increment=1.
- T2: pc_data=0, lower_byte=1, then execute as in REQ-008, or w_rd=1 for STA.
REQ-010 Absolute mode:
- T1: addr_lo_load=1, increment=1.
- T2: addr_hi_load=1, increment=1.
- T3: pc_data=0, lower_byte=0, then execute or store.
REQ-011 STA SHALL drive alu_op=PASS with all register enables 0.
REQ-012 After the last cycle of an instruction, t_state SHALL return to 0 on the next edge.
REQ-013 When mem_ready=0, t_state and the IR SHALL hold, and increment, addr loads and all *_con SHALL be 0 in that cycle.
REQ-014 flush=1 SHALL force t_state=0 on the next edge regardless of mem_ready, with no register writes in the flush cycle; the IR is preserved.
REQ-015 Outside active steps, outputs SHALL idle at: all 1-bit outputs 0, alu_op=PASS, branch_op=0. Decoded ALU ops never use branch outputs, so branch_uncon, branch_con and branch_op remain idle.
REQ-016 t_state SHALL never exceed 3.

Reset
REQ-017 rst low SHALL asynchronously set t_state=0, IR=0xEA, immediate=0, illegal=0, and all outputs to idle.
REQ-018 After rst rises, the first edge SHALL be a T0 fetch.
REQ-019 A reset mid-instruction SHALL abandon that instruction without any write.

Configuration
REQ-020 With DECODE_ILLEGAL_TRAP_EN defined, an illegal opcode SHALL:
- in T1, assert illegal=1 with idle controls;
- then enter HALT, holding all outputs idle and illegal=1 until reset; flush SHALL NOT exit HALT.
REQ-021 Without DECODE_ILLEGAL_TRAP_EN, an illegal opcode SHALL execute as a 2-cycle NOP (T1 idle, no increment), and illegal SHALL be tied to 0.

Structure
REQ-022 A shared package decoder_pkg SHALL hold:
- ALU op constants ADD..PASS (0..11);
- the addressing-mode enum (IMM, ZP, ABS, ILL);
- the operation enum;
- the state enum (T0..T3, HALT).
REQ-023 A combinational sub-module decode_rom SHALL map the IR to {operation, mode, alu_op, acc_write}; sequencing SHALL live in decode_sequencer.

Verification
REQ-024 The bench SHALL cover these directed scenarios:
- 0x69, 0x05 with ready → T1: alu_op=1, accumulator_con=1, status_con=1, immediate=0x05; sync=1 on cycle 3.
- 0xA5, 0x10, data 0x7F → T2: pc_data=0, lower_byte=1, alu_op=11, accumulator_con=1; 3 cycles total.
- 0x8D, 0x34, 0x12 → addr_lo_load in T1, addr_hi_load in T2, T3 w_rd=1 with enables 0; 4 cycles.
- 0x69 with mem_ready=0 for 2 cycles in T1 → t_state stays 1, all enables 0, then completes normally.
- flush in T2 of 0x6D → next cycle sync=1, t_state=0, no accumulator write.
- 0x89: with DECODE_ILLEGAL_TRAP_EN → illegal=1 and HALT until rst; without it → 2-cycle NOP, then next fetch.

Source files
------------

// File: rtl/decoder_pkg.sv
// Shared types and constants for the aaa-bbb-01 instruction decoder.
package decoder_pkg;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_ADC  = 4'd1;
  localparam logic [3:0] ALU_SBC  = 4'd2;
  localparam logic [3:0] ALU_AND  = 4'd3;
  localparam logic [3:0] ALU_EOR  = 4'd4;
  localparam logic [3:0] ALU_ORA  = 4'd5;
  localparam logic [3:0] ALU_ASL  = 4'd6;
  localparam logic [3:0] ALU_LSR  = 4'd7;
  localparam logic [3:0] ALU_ROL  = 4'd8;
  localparam logic [3:0] ALU_ROR  = 4'd9;
  localparam logic [3:0] ALU_INC  = 4'd10;
  localparam logic [3:0] ALU_PASS = 4'd11;

  localparam logic [7:0] IR_RESET = 8'hEA;

  typedef enum logic [1:0] {IMM, ZP, ABS, ILL} mode_t;

  // Encoding matches the aaa field of the opcode.
  typedef enum logic [2:0] {
    OP_ORA, OP_AND, OP_EOR, OP_ADC, OP_STA, OP_LDA, OP_CMP, OP_SBC
  } op_t;

  typedef enum logic [2:0] {T0, T1, T2, T3, HALT} state_t;

  function automatic logic [1:0] last_step(input mode_t m);
    case (m)
      ZP:      return 2'd2;
      ABS:     return 2'd3;
      default: return 2'd1;
    endcase
  endfunction

endpackage

// File: rtl/decode_rom.sv
// Combinational opcode decode: IR -> {operation, addressing mode, ALU op, accumulator write}.
module decode_rom
  import decoder_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] i_ir,
  output op_t               o_op,
  output mode_t             o_mode,
  output logic [3:0]        o_alu_op,
  output logic              o_acc_write
);

  always_comb begin
    o_op        = op_t'(i_ir[7:5]);
    o_mode      = ILL;
    o_alu_op    = ALU_PASS;
    o_acc_write = 1'b0;
    if (i_ir[1:0] == 2'b01) begin
      case (i_ir[4:2])
        3'b010:  o_mode = (o_op == OP_STA) ? ILL : IMM;
        3'b001:  o_mode = ZP;
        3'b011:  o_mode = ABS;
        default: o_mode = ILL;
      endcase
    end
    if (o_mode != ILL) begin
      case (o_op)
        OP_ORA: begin o_alu_op = ALU_ORA;  o_acc_write = 1'b1; end
        OP_AND: begin o_alu_op = ALU_AND;  o_acc_write = 1'b1; end
        OP_EOR: begin o_alu_op = ALU_EOR;  o_acc_write = 1'b1; end
        OP_ADC: begin o_alu_op = ALU_ADC;  o_acc_write = 1'b1; end
        OP_STA: begin o_alu_op = ALU_PASS; o_acc_write = 1'b0; end
        OP_LDA: begin o_alu_op = ALU_PASS; o_acc_write = 1'b1; end
        // CMP is a subtract that only updates the flags.
        OP_CMP: begin o_alu_op = ALU_SBC;  o_acc_write = 1'b0; end
        OP_SBC: begin o_alu_op = ALU_SBC;  o_acc_write = 1'b1; end
        default: begin o_alu_op = ALU_PASS; o_acc_write = 1'b0; end
      endcase
    end
  end

endmodule

// File: rtl/decode_sequencer.sv
// Per-cycle control sequencer (T0..T3) for aaa-bbb-01 opcodes.
// DECODE_ILLEGAL_TRAP_EN: illegal opcodes trap to HALT instead of running as a NOP.
module decode_sequencer
  import decoder_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 16,
  parameter int T_W    = 3
) (
  input  logic              clk_2,
  input  logic              rst,
  input  logic [DATA_W-1:0] instruction,
  input  logic              mem_ready,
  input  logic              flush,
  output logic              sync,
  output logic              w_rd,
  output logic              pc_data,
  output logic              increment,
  output logic              lower_byte,
  output logic              addr_lo_load,
  output logic              addr_hi_load,
  output logic              x_con,
  output logic              y_con,
  output logic              accumulator_con,
  output logic              status_con,
  output logic              stack_pointer_con,
  output logic              branch_uncon,
  output logic              branch_con,
  output logic [3:0]        alu_op,
  output logic [2:0]        branch_op,
  output logic [DATA_W-1:0] immediate,
  output logic [T_W-1:0]    t_state,
  output logic              illegal
);

`ifdef DECODE_ILLEGAL_TRAP_EN
  localparam logic TRAP_EN = 1'b1;
`else
  localparam logic TRAP_EN = 1'b0;
`endif

  if (ADDR_W <= DATA_W) begin : g_addr_w_check
    $error("ADDR_W must be wider than DATA_W");
  end

  state_t            r_state, w_next;
  logic [DATA_W-1:0] r_ir, r_imm;
  op_t               w_op;
  mode_t             w_mode;
  logic [3:0]        w_alu;
  logic              w_acc, w_go, w_exec;
  logic [1:0]        w_step;

  decode_rom #(.DATA_W(DATA_W)) u_rom (
    .i_ir        (r_ir),
    .o_op        (w_op),
    .o_mode      (w_mode),
    .o_alu_op    (w_alu),
    .o_acc_write (w_acc)
  );

  // A cycle only has side effects when memory completes and nothing is abandoned.
  assign w_go = mem_ready & ~flush;

  always_comb begin
    case (r_state)
      T1:      w_step = 2'd1;
      T2:      w_step = 2'd2;
      T3:      w_step = 2'd3;
      default: w_step = 2'd0;
    endcase
  end

  assign w_exec    = (w_mode != ILL) && (w_step == last_step(w_mode));
  assign t_state   = T_W'(w_step);
  assign immediate = r_imm;

  always_ff @(posedge clk_2 or negedge rst) begin
    if (!rst) r_state <= T0;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (r_state != HALT) begin
      if (flush) begin
        w_next = T0;
      end else if (mem_ready) begin
        case (r_state)
          T0:      w_next = T1;
          T1:      w_next = (w_mode == ILL) ? (TRAP_EN ? HALT : T0) : (w_exec ? T0 : T2);
          T2:      w_next = w_exec ? T0 : T3;
          default: w_next = T0;
        endcase
      end
    end
  end

  always_ff @(posedge clk_2 or negedge rst) begin
    if (!rst) begin
      r_ir  <= DATA_W'(IR_RESET);
      r_imm <= '0;
    end else begin
      if (r_state == T0 && w_go) r_ir <= instruction;
      if (w_exec && w_op != OP_STA && w_go) r_imm <= instruction;
    end
  end

  always_comb begin
    sync              = 1'b0;
    w_rd              = 1'b0;
    pc_data           = 1'b0;
    increment         = 1'b0;
    lower_byte        = 1'b0;
    addr_lo_load      = 1'b0;
    addr_hi_load      = 1'b0;
    x_con             = 1'b0;
    y_con             = 1'b0;
    accumulator_con   = 1'b0;
    status_con        = 1'b0;
    stack_pointer_con = 1'b0;
    branch_uncon      = 1'b0;
    branch_con        = 1'b0;
    alu_op            = ALU_PASS;
    branch_op         = 3'd0;
    illegal           = 1'b0;
    if (rst) begin
      if (r_state == T0) begin
        sync      = 1'b1;
        pc_data   = 1'b1;
        increment = w_go;
      end else if (w_exec) begin
        // Immediate operands come from PC; zero page/absolute from the latches.
        pc_data    = (w_mode == IMM);
        lower_byte = (w_mode == ZP);
        increment  = (w_mode == IMM) & w_go;
        if (w_op == OP_STA) begin
          w_rd = ~flush;
        end else begin
          alu_op          = w_alu;
          status_con      = w_go;
          accumulator_con = w_go & w_acc;
        end
      end else if (w_mode != ILL && r_state != HALT) begin
        pc_data      = 1'b1;
        increment    = w_go;
        addr_lo_load = w_go & (r_state == T1);
        addr_hi_load = w_go & (r_state == T2);
      end else begin
        illegal = TRAP_EN & ((r_state == T1) | (r_state == HALT));
      end
    end
  end

endmodule

// File: tb/tb_decode_sequencer.sv
// Self-checking bench for decode_sequencer: directed scenarios plus randomized traffic vs a cycle-count model.
module tb_decode_sequencer;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 16;
  localparam int T_W    = 3;
  localparam int OW     = 33;

`ifdef DECODE_ILLEGAL_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  // ALU code per aaa field: ORA AND EOR ADC STA LDA CMP SBC
  localparam logic [3:0] ALU_TAB [8] = '{4'd5, 4'd3, 4'd4, 4'd1, 4'd11, 4'd11, 4'd2, 4'd2};

  // clock / reset
  logic clk_2 = 1'b0;
  logic rst   = 1'b0;
  always #5 clk_2 = ~clk_2;

  logic [DATA_W-1:0] instruction = '0;
  logic              mem_ready   = 1'b0;
  logic              flush       = 1'b0;

  logic sync, w_rd, pc_data, increment, lower_byte, addr_lo_load, addr_hi_load;
  logic x_con, y_con, accumulator_con, status_con, stack_pointer_con;
  logic branch_uncon, branch_con, illegal;
  logic [3:0]        alu_op;
  logic [2:0]        branch_op;
  logic [DATA_W-1:0] immediate;
  logic [T_W-1:0]    t_state;

  decode_sequencer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .T_W(T_W)) dut (
    .clk_2             (clk_2),
    .rst               (rst),
    .instruction       (instruction),
    .mem_ready         (mem_ready),
    .flush             (flush),
    .sync              (sync),
    .w_rd              (w_rd),
    .pc_data           (pc_data),
    .increment         (increment),
    .lower_byte        (lower_byte),
    .addr_lo_load      (addr_lo_load),
    .addr_hi_load      (addr_hi_load),
    .x_con             (x_con),
    .y_con             (y_con),
    .accumulator_con   (accumulator_con),
    .status_con        (status_con),
    .stack_pointer_con (stack_pointer_con),
    .branch_uncon      (branch_uncon),
    .branch_con        (branch_con),
    .alu_op            (alu_op),
    .branch_op         (branch_op),
    .immediate         (immediate),
    .t_state           (t_state),
    .illegal           (illegal)
  );

  logic [OW-1:0] dut_vec;
  assign dut_vec = {sync, w_rd, pc_data, increment, lower_byte, addr_lo_load, addr_hi_load,
                    x_con, y_con, accumulator_con, status_con, stack_pointer_con,
                    branch_uncon, branch_con, alu_op, branch_op, immediate, t_state, illegal};

  int n_chk = 0;
  int n_err = 0;
  logic [OW-1:0] exp_q[$];

  // reference model: position within the current instruction
  int         m_cyc  = 0;
  logic [7:0] m_ir   = 8'hEA;
  logic [7:0] m_imm  = 8'h00;
  bit         m_halt = 1'b0;

  function automatic bit f_legal(input logic [7:0] ir);
    int bbb;
    bbb = int'(ir[4:2]);
    return (ir[1:0] == 2'b01) && (bbb >= 1) && (bbb <= 3) && (ir != 8'h89);
  endfunction

  function automatic int f_len(input logic [7:0] ir);
    if (!f_legal(ir)) return 2;
    case (ir[4:2])
      3'b010:  return 2;
      3'b001:  return 3;
      default: return 4;
    endcase
  endfunction

  function automatic bit f_sta(input logic [7:0] ir);
    return ir[7:5] == 3'd4;
  endfunction

  function automatic bit f_acc(input logic [7:0] ir);
    return (ir[7:5] != 3'd4) && (ir[7:5] != 3'd6);
  endfunction

  function automatic logic [3:0] f_alu(input logic [7:0] ir);
    return ALU_TAB[ir[7:5]];
  endfunction

  always @(posedge clk_2 or negedge rst) begin
    if (!rst) begin
      m_cyc  <= 0;
      m_ir   <= 8'hEA;
      m_imm  <= 8'h00;
      m_halt <= 1'b0;
    end else if (m_halt) begin
    end else if (flush) begin
      m_cyc <= 0;
    end else if (mem_ready) begin
      if (m_cyc == 0) begin
        m_ir  <= instruction;
        m_cyc <= 1;
      end else begin
        if (f_legal(m_ir) && m_cyc == f_len(m_ir) - 1 && !f_sta(m_ir)) m_imm <= instruction;
        if (!f_legal(m_ir) && TRAP) begin
          m_halt <= 1'b1;
          m_cyc  <= 0;
        end else if (m_cyc == f_len(m_ir) - 1) begin
          m_cyc <= 0;
        end else begin
          m_cyc <= m_cyc + 1;
        end
      end
    end
  end

  function automatic logic [OW-1:0] model_out();
    logic s, wr, pc, inc, lb, lo, hi, acc, st, ill;
    logic [3:0] alu;
    bit go;
    int len;
    s = 0; wr = 0; pc = 0; inc = 0; lb = 0; lo = 0; hi = 0; acc = 0; st = 0; ill = 0;
    alu = 4'd11;
    len = f_len(m_ir);
    go  = mem_ready && !flush;
    if (rst && m_halt) begin
      ill = 1'b1;
    end else if (rst) begin
      if (m_cyc == 0) begin
        s = 1; pc = 1; inc = go;
      end else if (!f_legal(m_ir)) begin
        ill = TRAP;
      end else if (m_cyc == len - 1) begin
        pc  = (len == 2);
        lb  = (len == 3);
        inc = go && (len == 2);
        if (f_sta(m_ir)) wr = !flush;
        else begin
          alu = f_alu(m_ir);
          st  = go;
          acc = go && f_acc(m_ir);
        end
      end else begin
        pc = 1; inc = go;
        lo = go && (m_cyc == 1);
        hi = go && (m_cyc == 2);
      end
    end
    return {s, wr, pc, inc, lb, lo, hi, 1'b0, 1'b0, acc, st, 1'b0, 1'b0, 1'b0,
            alu, 3'd0, m_imm, 3'(m_cyc), ill};
  endfunction

  // predictor: push expectation once the cycle's inputs have settled
  initial forever begin
    @(posedge clk_2);
    #2;
    exp_q.push_back(model_out());
  end

  // scoreboard compare on every falling edge
  initial forever begin
    @(negedge clk_2);
    n_chk++;
    if (exp_q.size() == 0) begin
      n_err++;
      $display("FAIL cycle_cmp t=%0t no expectation queued", $time);
    end else begin
      logic [OW-1:0] e;
      e = exp_q.pop_front();
      if (dut_vec !== e) begin
        n_err++;
        $display("FAIL cycle_cmp t=%0t got=%h exp=%h", $time, dut_vec, e);
      end
    end
  end

  // driver tasks
  task automatic drive(input logic [7:0] d, input logic rdy, input logic fl);
    @(posedge clk_2);
    #1;
    instruction = d;
    mem_ready   = rdy;
    flush       = fl;
    #5;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  initial begin
    rst = 1'b0;
    repeat (3) @(posedge clk_2);
    #6;
    chk("rst_sync", 32'(sync), 0);
    chk("rst_tstate", 32'(t_state), 0);
    chk("rst_imm", 32'(immediate), 0);
    chk("rst_illegal", 32'(illegal), 0);
    chk("rst_alu", 32'(alu_op), 11);
    chk("rst_inc", 32'(increment), 0);

    // ADC #$05
    @(posedge clk_2); #1;
    rst = 1'b1; instruction = 8'h69; mem_ready = 1'b1; flush = 1'b0;
    #5;
    chk("imm_t0_sync", 32'(sync), 1);
    chk("imm_t0_t", 32'(t_state), 0);
    drive(8'h05, 1, 0);
    chk("imm_t1_alu", 32'(alu_op), 1);
    chk("imm_t1_acc", 32'(accumulator_con), 1);
    chk("imm_t1_st", 32'(status_con), 1);
    chk("imm_t1_t", 32'(t_state), 1);
    // LDA $10
    drive(8'hA5, 1, 0);
    chk("imm_c3_sync", 32'(sync), 1);
    chk("imm_latched", 32'(immediate), 8'h05);
    drive(8'h10, 1, 0);
    chk("zp_t1_lo", 32'(addr_lo_load), 1);
    chk("zp_t1_inc", 32'(increment), 1);
    drive(8'h7F, 1, 0);
    chk("zp_t2_pc", 32'(pc_data), 0);
    chk("zp_t2_lb", 32'(lower_byte), 1);
    chk("zp_t2_alu", 32'(alu_op), 11);
    chk("zp_t2_acc", 32'(accumulator_con), 1);
    chk("zp_t2_t", 32'(t_state), 2);
    // STA $1234
    drive(8'h8D, 1, 0);
    chk("zp_c4_sync", 32'(sync), 1);
    chk("zp_latched", 32'(immediate), 8'h7F);
    drive(8'h34, 1, 0);
    chk("abs_t1_lo", 32'(addr_lo_load), 1);
    drive(8'h12, 1, 0);
    chk("abs_t2_hi", 32'(addr_hi_load), 1);
    chk("abs_t2_t", 32'(t_state), 2);
    drive(8'h55, 1, 0);
    chk("abs_t3_t", 32'(t_state), 3);
    chk("abs_t3_wr", 32'(w_rd), 1);
    chk("abs_t3_acc", 32'(accumulator_con), 0);
    chk("abs_t3_st", 32'(status_con), 0);
    chk("abs_t3_pc", 32'(pc_data), 0);
    // ADC # with two wait states in T1
    drive(8'h69, 1, 0);
    chk("abs_c5_sync", 32'(sync), 1);
    for (int i = 0; i < 2; i++) begin
      drive(8'hAA, 0, 0);
      chk("wait_t", 32'(t_state), 1);
      chk("wait_acc", 32'(accumulator_con), 0);
      chk("wait_st", 32'(status_con), 0);
      chk("wait_inc", 32'(increment), 0);
    end
    drive(8'hAA, 1, 0);
    chk("wait_done_acc", 32'(accumulator_con), 1);
    // ADC $xxxx flushed in T2
    drive(8'h6D, 1, 0);
    chk("wait_next_sync", 32'(sync), 1);
    chk("wait_latched", 32'(immediate), 8'hAA);
    drive(8'h01, 1, 0);
    chk("fl_t1_lo", 32'(addr_lo_load), 1);
    drive(8'h02, 1, 1);
    chk("fl_t2_t", 32'(t_state), 2);
    chk("fl_t2_hi", 32'(addr_hi_load), 0);
    chk("fl_t2_acc", 32'(accumulator_con), 0);
    // STA # is illegal
    drive(8'h89, 1, 0);
    chk("fl_next_sync", 32'(sync), 1);
    chk("fl_next_t", 32'(t_state), 0);
`ifdef DECODE_ILLEGAL_TRAP_EN
    drive(8'h00, 1, 0);
    chk("trap_t1_ill", 32'(illegal), 1);
    chk("trap_t1_inc", 32'(increment), 0);
    for (int i = 0; i < 4; i++) begin
      drive(8'h69, 1, i[0]);
      chk("halt_ill", 32'(illegal), 1);
      chk("halt_sync", 32'(sync), 0);
      chk("halt_t", 32'(t_state), 0);
    end
`else
    drive(8'h00, 1, 0);
    chk("nop_t1_t", 32'(t_state), 1);
    chk("nop_t1_ill", 32'(illegal), 0);
    chk("nop_t1_inc", 32'(increment), 0);
    chk("nop_t1_pc", 32'(pc_data), 0);
    drive(8'h69, 1, 0);
    chk("nop_next_sync", 32'(sync), 1);
    chk("nop_next_t", 32'(t_state), 0);
    drive(8'h05, 1, 0);
    chk("nop_after_acc", 32'(accumulator_con), 1);
`endif
    @(posedge clk_2); #1;
    rst = 1'b0;
    #5;
    chk("rst2_ill", 32'(illegal), 0);
    chk("rst2_sync", 32'(sync), 0);
    @(posedge clk_2); #1;
    rst = 1'b1; instruction = 8'h69; mem_ready = 1'b1; flush = 1'b0;
    #5;
    chk("rst2_fetch", 32'(sync), 1);
    // reset arrives during T1 of ADC #
    @(posedge clk_2); #1;
    rst = 1'b0; instruction = 8'h05;
    #5;
    chk("midrst_acc", 32'(accumulator_con), 0);
    chk("midrst_st", 32'(status_con), 0);
    chk("midrst_t", 32'(t_state), 0);
    chk("midrst_imm", 32'(immediate), 0);
    @(posedge clk_2); #1;
    rst = 1'b1;
    #5;
    chk("midrst_fetch", 32'(sync), 1);

    for (int i = 0; i < 3000; i++) begin
      @(posedge clk_2); #1;
      rst = ($urandom_range(0, 199) != 0);
      if ($urandom_range(0, 3) != 0)
        instruction = {3'($urandom_range(0, 7)), 3'($urandom_range(1, 3)), 2'b01};
      else
        instruction = 8'($urandom_range(0, 255));
      mem_ready = ($urandom_range(0, 4) != 0);
      flush     = ($urandom_range(0, 19) == 0);
    end
    @(posedge clk_2); #1;
    rst = 1'b1;
    repeat (2) @(negedge clk_2);
    #1;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
